// File: rtl/id_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_stage
// Brief    : Decode stage with 4x19 register file, writeback bypass, load-use
//            style hazard stall and the ID/EX pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module id_exe_stage #(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] InstrD,
    input  logic              InstrValidD,
    output logic              StallF,
    input  logic              RegWriteW,
    input  logic [1:0]        r1W_addr,
    input  logic [DATA_W-1:0] ResultW,
    output logic              RegWriteE,
    output logic              memtoRegE,
    output logic              memwriteE,
    output logic [19:0]       AluControlE,
    output logic              AluSrcE,
    output logic [DATA_W-1:0] RD1_2_dataE,
    output logic [DATA_W-1:0] RD3_dataE,
    output logic [7:0]        addrE,
    output logic [1:0]        r1E_addr,
    output logic              IllegalE
);

    localparam logic [4:0] c_OP_NOP = 5'd0;
    localparam logic [4:0] c_OP_ADD = 5'd1;
    localparam logic [4:0] c_OP_SUB = 5'd2;
    localparam logic [4:0] c_OP_AND = 5'd3;
    localparam logic [4:0] c_OP_OR  = 5'd4;
    localparam logic [4:0] c_OP_LD  = 5'd5;
    localparam logic [4:0] c_OP_ST  = 5'd6;
    localparam logic [4:0] c_OP_FFT = 5'd7;
    localparam logic [4:0] c_OP_ENC = 5'd8;
    localparam logic [4:0] c_OP_DEC = 5'd9;

    logic [DATA_W-1:0] r_regFile [4];

    logic [4:0] w_opcode;
    logic [1:0] w_r1;
    logic [1:0] w_r2;
    logic [1:0] w_r3;
    logic [7:0] w_addr;

    assign w_opcode = InstrD[18:14];
    assign w_r1     = InstrD[13:12];
    assign w_r2     = InstrD[11:10];
    assign w_r3     = InstrD[9:8];
    assign w_addr   = InstrD[7:0];

    logic       w_regWrite;
    logic       w_memtoReg;
    logic       w_memWrite;
    logic [2:0] w_aluCtl;
    logic       w_aluSrc;
    logic       w_illegal;
    logic       w_aluOp;
    logic       w_rd12En;
    logic       w_rd3En;
    logic       w_readR1;
    logic       w_readR2;
    logic       w_readR3;

    always_comb begin
        w_regWrite = 1'b0;
        w_memtoReg = 1'b0;
        w_memWrite = 1'b0;
        w_aluCtl   = 3'd0;
        w_aluSrc   = 1'b0;
        w_illegal  = 1'b0;
        w_aluOp    = 1'b0;
        w_rd12En   = 1'b0;
        w_rd3En    = 1'b0;
        w_readR1   = 1'b0;
        w_readR2   = 1'b0;
        w_readR3   = 1'b0;
        case (w_opcode)
            c_OP_NOP: ;
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                w_regWrite = 1'b1;
                w_aluCtl   = w_opcode[2:0];
                w_aluOp    = 1'b1;
                w_rd12En   = 1'b1;
                w_rd3En    = 1'b1;
                w_readR2   = 1'b1;
                w_readR3   = 1'b1;
            end
            c_OP_LD: begin
                w_regWrite = 1'b1;
                w_memtoReg = 1'b1;
                w_aluSrc   = 1'b1;
            end
            c_OP_ST: begin
                w_memWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_rd12En   = 1'b1;
                w_readR1   = 1'b1;
            end
            c_OP_FFT, c_OP_ENC, c_OP_DEC: begin
                w_memWrite = 1'b1;
                w_aluCtl   = (w_opcode == c_OP_FFT) ? 3'd5 :
                             (w_opcode == c_OP_ENC) ? 3'd6 : 3'd7;
                w_rd12En   = 1'b1;
                w_rd3En    = 1'b1;
                w_readR1   = 1'b1;
                w_readR2   = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ALU ops read {r2,r3}; memory-side ops read {r1,r2}, so the port address shifts by one field.
    logic [1:0]        w_rd12Addr;
    logic [1:0]        w_rd3Addr;
    logic [DATA_W-1:0] w_rd12Raw;
    logic [DATA_W-1:0] w_rd3Raw;
    logic [DATA_W-1:0] w_rd12;
    logic [DATA_W-1:0] w_rd3;

    assign w_rd12Addr = w_aluOp ? w_r2 : w_r1;
    assign w_rd3Addr  = w_aluOp ? w_r3 : w_r2;
    assign w_rd12Raw  = (RegWriteW && (r1W_addr == w_rd12Addr)) ? ResultW : r_regFile[w_rd12Addr];
    assign w_rd3Raw   = (RegWriteW && (r1W_addr == w_rd3Addr))  ? ResultW : r_regFile[w_rd3Addr];
    assign w_rd12     = w_rd12En ? w_rd12Raw : '0;
    assign w_rd3      = w_rd3En  ? w_rd3Raw  : '0;

    logic w_hazard;

    assign w_hazard = (w_readR1 && (r1E_addr == w_r1)) ||
                      (w_readR2 && (r1E_addr == w_r2)) ||
                      (w_readR3 && (r1E_addr == w_r3));
    assign StallF   = !rst && InstrValidD && RegWriteE && w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (RegWriteW) begin
            r_regFile[r1W_addr] <= ResultW;
        end
    end

    // A bubble clears RegWriteE, which is what guarantees a stall lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst || !InstrValidD || StallF) begin
            RegWriteE   <= 1'b0;
            memtoRegE   <= 1'b0;
            memwriteE   <= 1'b0;
            AluControlE <= '0;
            AluSrcE     <= 1'b0;
            RD1_2_dataE <= '0;
            RD3_dataE   <= '0;
            addrE       <= '0;
            r1E_addr    <= '0;
            IllegalE    <= 1'b0;
        end else begin
            RegWriteE   <= w_regWrite;
            memtoRegE   <= w_memtoReg;
            memwriteE   <= w_memWrite;
            AluControlE <= {17'd0, w_aluCtl};
            AluSrcE     <= w_aluSrc;
            RD1_2_dataE <= w_rd12;
            RD3_dataE   <= w_rd3;
            addrE       <= w_addr;
            r1E_addr    <= w_r1;
            IllegalE    <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_exe_stage
// Brief    : Scoreboarded random/directed bench for id_exe_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] InstrD = '0;
    logic        InstrValidD = 1'b0;
    logic        StallF;
    logic        RegWriteW = 1'b0;
    logic [1:0]  r1W_addr = '0;
    logic [18:0] ResultW = '0;
    logic        RegWriteE, memtoRegE, memwriteE, AluSrcE, IllegalE;
    logic [19:0] AluControlE;
    logic [18:0] RD1_2_dataE, RD3_dataE;
    logic [7:0]  addrE;
    logic [1:0]  r1E_addr;

    id_exe_stage #(.DATA_W(19)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .InstrValidD(InstrValidD), .StallF(StallF),
        .RegWriteW(RegWriteW), .r1W_addr(r1W_addr), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .memtoRegE(memtoRegE), .memwriteE(memwriteE),
        .AluControlE(AluControlE), .AluSrcE(AluSrcE), .RD1_2_dataE(RD1_2_dataE),
        .RD3_dataE(RD3_dataE), .addrE(addrE), .r1E_addr(r1E_addr), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic [19:0] alu;
        logic        src;
        logic [18:0] a;
        logic [18:0] b;
        logic [7:0]  addr;
        logic [1:0]  r1;
        logic        ill;
    } e_t;

    e_t          q[$];
    int          errors = 0;
    int          checks = 0;
    logic [18:0] m_reg [4];
    e_t          m_e;
    logic        lastStall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] mk(input int op, input int a, input int b, input int c, input int ad);
        logic [18:0] v;
        v = {5'(op), 2'(a), 2'(b), 2'(c), 8'(ad)};
        return v;
    endfunction

    function automatic logic [18:0] rd(input logic [1:0] a, input logic rwW, input logic [1:0] wA,
                                       input logic [18:0] res);
        return (rwW && wA == a) ? res : m_reg[a];
    endfunction

    // Behavioural reference: what E should hold after the coming edge, and whether D must stall now.
    task automatic model(input logic rstv, input logic valid, input logic [18:0] instr, input logic rwW,
                         input logic [1:0] wA, input logic [18:0] res, output e_t e, output logic stall);
        e_t         ne;
        logic [3:0] mask;
        logic [1:0] r1, r2, r3;
        int         op;
        op = int'(instr[18:14]);
        r1 = instr[13:12];
        r2 = instr[11:10];
        r3 = instr[9:8];
        ne = '0;
        ne.addr = instr[7:0];
        ne.r1 = r1;
        mask = 4'b0;
        case (op)
            0: ;
            1, 2, 3, 4: begin
                ne.rw = 1'b1; ne.alu = 20'(op);
                ne.a = rd(r2, rwW, wA, res); ne.b = rd(r3, rwW, wA, res);
                mask = (4'b1 << r2) | (4'b1 << r3);
            end
            5: begin ne.rw = 1'b1; ne.mr = 1'b1; ne.src = 1'b1; end
            6: begin
                ne.mw = 1'b1; ne.src = 1'b1; ne.a = rd(r1, rwW, wA, res);
                mask = 4'b1 << r1;
            end
            7, 8, 9: begin
                ne.mw = 1'b1; ne.alu = 20'(op - 2);
                ne.a = rd(r1, rwW, wA, res); ne.b = rd(r2, rwW, wA, res);
                mask = (4'b1 << r1) | (4'b1 << r2);
            end
            default: ne.ill = 1'b1;
        endcase
        stall = !rstv && valid && m_e.rw && mask[m_e.r1];
        e = (rstv || !valid || stall) ? '0 : ne;
    endtask

    task automatic cycle(input logic rstv, input logic valid, input logic [18:0] instr, input logic rwW,
                         input logic [1:0] wA, input logic [18:0] res);
        e_t   e;
        logic stall;
        @(negedge clk);
        rst = rstv; InstrValidD = valid; InstrD = instr;
        RegWriteW = rwW; r1W_addr = wA; ResultW = res;
        #1;
        model(rstv, valid, instr, rwW, wA, res, e, stall);
        chk("StallF", 32'(StallF), 32'(stall));
        q.push_back(e);
        if (rstv) begin
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
            m_e = '0;
        end else begin
            if (rwW) m_reg[wA] = res;
            m_e = e;
        end
        lastStall = stall;
    endtask

    initial begin : monitor
        e_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteE",   32'(RegWriteE),   32'(e.rw));
                chk("memtoRegE",   32'(memtoRegE),   32'(e.mr));
                chk("memwriteE",   32'(memwriteE),   32'(e.mw));
                chk("AluControlE", 32'(AluControlE), 32'(e.alu));
                chk("AluSrcE",     32'(AluSrcE),     32'(e.src));
                chk("RD1_2_dataE", 32'(RD1_2_dataE), 32'(e.a));
                chk("RD3_dataE",   32'(RD3_dataE),   32'(e.b));
                chk("addrE",       32'(addrE),       32'(e.addr));
                chk("r1E_addr",    32'(r1E_addr),    32'(e.r1));
                chk("IllegalE",    32'(IllegalE),    32'(e.ill));
            end
        end
    end

    initial begin : driver
        logic [18:0] hInstr;
        logic        hValid;
        logic [31:0] rnd;
        int          op;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_e = '0;
        cycle(1, 0, '0, 0, 0, '0);
        cycle(1, 1, mk(1, 1, 2, 3, 7), 1, 1, 19'h1234);
        // writeback then ADD reading the written register
        cycle(0, 0, '0, 1, 2, 19'h00005);
        cycle(0, 1, mk(1, 1, 2, 2, 0), 0, 0, '0);
        // dependent SUB stalls once, then issues with the bypassed result
        cycle(0, 1, mk(1, 3, 0, 0, 0), 0, 0, '0);
        cycle(0, 1, mk(2, 0, 3, 1, 0), 0, 0, '0);
        cycle(0, 1, mk(2, 0, 3, 1, 0), 1, 3, 19'h7FFFF);
        cycle(0, 1, mk(5, 1, 0, 0, 8'h2A), 0, 0, '0);
        cycle(0, 1, mk(5, 1, 0, 0, 8'h2A), 0, 0, '0);
        cycle(0, 0, '0, 1, 0, 19'h12345);
        cycle(0, 1, mk(6, 0, 0, 0, 8'h11), 0, 0, '0);
        cycle(0, 1, mk(7, 1, 2, 0, 8'h22), 0, 0, '0);
        cycle(0, 1, mk(31, 2, 1, 0, 8'h55), 0, 0, '0);
        cycle(0, 1, mk(8, 2, 1, 0, 0), 0, 0, '0);
        cycle(0, 1, mk(9, 3, 0, 0, 0), 0, 0, '0);
        // reset while a hazard is pending, with a competing writeback
        cycle(0, 0, '0, 1, 1, 19'h0AAAA);
        cycle(0, 0, '0, 1, 2, 19'h05555);
        cycle(0, 1, mk(1, 3, 1, 2, 0), 1, 3, 19'h33333);
        cycle(0, 1, mk(2, 0, 3, 1, 0), 0, 0, '0);
        cycle(0, 1, mk(1, 3, 1, 2, 0), 0, 0, '0);
        cycle(1, 1, mk(2, 0, 3, 1, 0), 1, 2, 19'h7FFFF);
        cycle(0, 1, mk(7, 3, 2, 0, 0), 0, 0, '0);
        cycle(0, 1, mk(6, 1, 0, 0, 0), 0, 0, '0);
        cycle(0, 1, mk(1, 0, 0, 3, 0), 0, 0, '0);
        hInstr = '0;
        hValid = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!lastStall) begin
                rnd = $urandom();
                op = $urandom_range(0, 12);
                if (op > 9) op = $urandom_range(10, 31);
                hInstr = {5'(op), rnd[13:0]};
                hValid = ($urandom_range(0, 7) != 0);
            end
            cycle(($urandom_range(0, 59) == 0), hValid, hInstr, ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), 19'($urandom()));
        end
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
